// File: rtl/seq_datapath_pkg.sv
// Shared widths and Y-source encodings for the microsequencer datapath.
// No logic here; constants only.
package seq_datapath_pkg;

    localparam int AW    = 12;
    localparam int DEPTH = 5;
    localparam int SPW   = 3;

    localparam logic [1:0] SEL_D  = 2'b00;
    localparam logic [1:0] SEL_R  = 2'b01;
    localparam logic [1:0] SEL_F  = 2'b10;
    localparam logic [1:0] SEL_PC = 2'b11;

endpackage

// File: rtl/seq_datapath_stack.sv
// seq_stack: 5-deep return-address LIFO with saturating top overwrite; updates on clk, f/fulln are state decodes.
// Latency: push/pop visible one clock later. No backpressure: a push when full overwrites the top entry.
module seq_stack
    import seq_datapath_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [AW-1:0]   din,
    output logic [AW-1:0]   f,
    output logic            fulln,
    output logic [SPW-1:0]  sp
);

    logic [AW-1:0]  mem [DEPTH];
    logic           wr_en;
    logic [SPW-1:0] wr_idx;
    logic [SPW-1:0] sp_nxt;

    // clear dominates; push+pop with entries replaces the top in place
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        sp_nxt = sp;
        if (clear) begin
            sp_nxt = '0;
            if (push) begin
                wr_en  = 1'b1;
                sp_nxt = SPW'(1);
            end
        end else if (push) begin
            wr_en = 1'b1;
            if (pop && sp != '0) begin
                wr_idx = sp - SPW'(1);
            end else if (sp < SPW'(DEPTH)) begin
                wr_idx = sp;
                sp_nxt = sp + SPW'(1);
            end else begin
                wr_idx = SPW'(DEPTH - 1);
            end
        end else if (pop && sp != '0) begin
            sp_nxt = sp - SPW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            sp <= sp_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && wr_idx == SPW'(i)) mem[i] <= din;
            end
        end
    end

    always_comb begin
        f = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp == SPW'(i + 1)) f = mem[i];
        end
    end

    assign fulln = (sp != SPW'(DEPTH));

endmodule

// File: rtl/seq_datapath.sv
// Microsequencer datapath: Y mux, uPC incrementer, loop counter R and return stack; y/zeror are combinational.
// Latency: uPC, R and stack update on the next clk edge. No backpressure: every clock commits.
module seq_datapath
    import seq_datapath_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   d,
    input  logic            ci,
    input  logic            rldn,
    input  logic            plrc,
    input  logic            dec,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic            respc,
    input  logic [1:0]      selmux,
    output logic [AW-1:0]   y,
    output logic            zeror,
    output logic            fulln,
    output logic [SPW-1:0]  sp
);

    logic [AW-1:0] upc;
    logic [AW-1:0] r;
    logic [AW-1:0] f;

    seq_stack u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (upc),
        .f     (f),
        .fulln (fulln),
        .sp    (sp)
    );

    always_comb begin
        y = '0;
        if (!respc) begin
            case (selmux)
                SEL_D:   y = d;
                SEL_R:   y = r;
                SEL_F:   y = f;
                default: y = upc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc <= '0;
            r   <= '0;
        end else begin
            upc <= y + AW'(ci);
            if (!rldn || plrc) r <= d;
            else if (dec)      r <= r - AW'(1);
        end
    end

    assign zeror = (r == '0);

endmodule

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath: directed scenarios plus random stimulus against a queue-based model.
module tb_seq_datapath;

    logic        clk;
    logic        rst_n;
    logic [11:0] d;
    logic        ci, rldn, plrc, dec, clear, push, pop, respc;
    logic [1:0]  selmux;
    logic [11:0] y;
    logic        zeror, fulln;
    logic [2:0]  sp;

    int checks   = 0;
    int failures = 0;

    logic [11:0] m_upc;
    logic [11:0] m_r;
    logic [11:0] m_q[$];

    seq_datapath dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (d),
        .ci     (ci),
        .rldn   (rldn),
        .plrc   (plrc),
        .dec    (dec),
        .clear  (clear),
        .push   (push),
        .pop    (pop),
        .respc  (respc),
        .selmux (selmux),
        .y      (y),
        .zeror  (zeror),
        .fulln  (fulln),
        .sp     (sp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] m_top();
        return (m_q.size() > 0) ? m_q[m_q.size() - 1] : 12'h000;
    endfunction

    function automatic logic [11:0] m_y();
        if (respc) return 12'h000;
        case (selmux)
            2'd0:    return d;
            2'd1:    return m_r;
            2'd2:    return m_top();
            default: return m_upc;
        endcase
    endfunction

    task automatic m_reset();
        m_upc = '0;
        m_r   = '0;
        m_q.delete();
    endtask

    task automatic idle();
        d = '0; ci = 0; rldn = 1; plrc = 0; dec = 0;
        clear = 0; push = 0; pop = 0; respc = 0; selmux = 2'd3;
    endtask

    // one clock edge; model advances from the pre-edge inputs
    task automatic tick();
        logic [11:0] ny;
        logic        run;
        ny  = m_y();
        run = rst_n;
        @(posedge clk);
        if (run) begin
            if (clear) begin
                m_q.delete();
                if (push) m_q.push_back(m_upc);
            end else if (push && pop && m_q.size() > 0) begin
                m_q[m_q.size() - 1] = m_upc;
            end else if (push) begin
                if (m_q.size() < 5) m_q.push_back(m_upc);
                else m_q[4] = m_upc;
            end else if (pop && m_q.size() > 0) begin
                void'(m_q.pop_back());
            end
            m_upc = ny + {11'd0, ci};
            if (!rldn || plrc) m_r = d;
            else if (dec) m_r = m_r - 12'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #1;
        m_reset();
        checks++; if (y !== 12'h000) begin failures++; $display("FAIL reset_y got=%h exp=000", y); end
        checks++; if (sp !== 3'd0 || zeror !== 1'b1 || fulln !== 1'b1) begin failures++; $display("FAIL reset_flags got sp=%0d zeror=%b fulln=%b exp 0/1/1", sp, zeror, fulln); end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        rldn = 0; d = 12'h123; selmux = 2'd3; tick();
        rldn = 1; push = 1; ci = 1; tick(); tick(); tick();
        idle(); selmux = 2'd1; #1;
        checks++; if (y !== 12'h123 || sp !== 3'd3) begin failures++; $display("FAIL reset_setup got y=%h sp=%0d exp 123/3", y, sp); end
        // reset lands mid-cycle with a push and load pending
        push = 1; rldn = 0; d = 12'h555; selmux = 2'd3;
        @(posedge clk); #3;
        m_upc = m_y() + 12'd0; // model refresh, superseded by the reset that follows
        rst_n = 0; #1;
        m_reset();
        selmux = 2'd1;
        #1;
        checks++; if (y !== 12'h000 || zeror !== 1'b1) begin failures++; $display("FAIL reset_async_r got y=%h zeror=%b exp 000/1", y, zeror); end
        checks++; if (sp !== 3'd0 || fulln !== 1'b1) begin failures++; $display("FAIL reset_async_sp got sp=%0d fulln=%b exp 0/1", sp, fulln); end
        selmux = 2'd3; #1;
        checks++; if (y !== 12'h000) begin failures++; $display("FAIL reset_async_y got=%h exp=000", y); end
        @(posedge clk); #1;
        checks++; if (sp !== 3'd0 || y !== 12'h000) begin failures++; $display("FAIL reset_held got sp=%0d y=%h exp 0/000", sp, y); end
        idle();
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic test_loop_count();
        idle(); rldn = 0; d = 12'h003; tick();
        idle(); selmux = 2'd1; #1;
        checks++; if (y !== 12'h003 || zeror !== 1'b0) begin failures++; $display("FAIL loop_load got R=%h zeror=%b exp 003/0", y, zeror); end
        dec = 1; tick(); tick(); tick();
        #1;
        checks++; if (y !== 12'h000 || zeror !== 1'b1) begin failures++; $display("FAIL loop_zero got R=%h zeror=%b exp 000/1", y, zeror); end
        tick();
        checks++; if (y !== 12'hFFF || zeror !== 1'b0) begin failures++; $display("FAIL loop_wrap got R=%h zeror=%b exp FFF/0", y, zeror); end
        idle();
    endtask

    task automatic test_overflow();
        idle(); selmux = 2'd0; d = 12'h010; tick();
        idle(); push = 1; ci = 1;
        repeat (6) tick();
        idle(); selmux = 2'd2; #1;
        checks++; if (sp !== 3'd5 || fulln !== 1'b0) begin failures++; $display("FAIL ovf_full got sp=%0d fulln=%b exp 5/0", sp, fulln); end
        checks++; if (y !== 12'h015) begin failures++; $display("FAIL ovf_top got F=%h exp 015", y); end
        pop = 1; tick(); pop = 0; #1;
        checks++; if (sp !== 3'd4 || fulln !== 1'b1 || y !== 12'h013) begin failures++; $display("FAIL ovf_pop got sp=%0d fulln=%b F=%h exp 4/1/013", sp, fulln, y); end
        idle();
    endtask

    task automatic test_underflow_clear();
        idle(); pop = 1;
        repeat (6) tick();
        tick();
        idle(); selmux = 2'd2; #1;
        checks++; if (sp !== 3'd0 || y !== 12'h000) begin failures++; $display("FAIL udf_pop got sp=%0d F=%h exp 0/000", sp, y); end
        idle(); push = 1; repeat (4) tick();
        idle(); selmux = 2'd0; d = 12'h2A0; tick();
        idle(); #1;
        checks++; if (sp !== 3'd4 || y !== 12'h2A0) begin failures++; $display("FAIL clr_setup got sp=%0d uPC=%h exp 4/2A0", sp, y); end
        clear = 1; push = 1; tick();
        idle(); selmux = 2'd2; #1;
        checks++; if (sp !== 3'd1 || y !== 12'h2A0) begin failures++; $display("FAIL clr_push got sp=%0d F=%h exp 1/2A0", sp, y); end
        idle();
    endtask

    task automatic test_ymux_incr();
        idle(); respc = 1; selmux = 2'd0; d = 12'hABC; #1;
        checks++; if (y !== 12'h000) begin failures++; $display("FAIL respc got y=%h exp 000", y); end
        respc = 0; ci = 1; #1;
        checks++; if (y !== 12'hABC) begin failures++; $display("FAIL sel_d got y=%h exp ABC", y); end
        tick();
        idle(); #1;
        checks++; if (y !== 12'hABD) begin failures++; $display("FAIL incr got uPC=%h exp ABD", y); end
        selmux = 2'd0; d = 12'hFFF; ci = 1; tick();
        idle(); #1;
        checks++; if (y !== 12'h000) begin failures++; $display("FAIL incr_wrap got uPC=%h exp 000", y); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            d      = 12'($urandom);
            ci     = 1'($urandom);
            rldn   = ($urandom_range(0, 7) != 0);
            plrc   = ($urandom_range(0, 7) == 0);
            dec    = 1'($urandom);
            clear  = ($urandom_range(0, 9) == 0);
            push   = 1'($urandom);
            pop    = 1'($urandom);
            respc  = ($urandom_range(0, 7) == 0);
            selmux = 2'($urandom);
            #1;
            checks++;
            if (y !== m_y() || zeror !== (m_r == 12'd0) || sp !== 3'(m_q.size()) || fulln !== (m_q.size() != 5)) begin
                failures++;
                $display("FAIL rand_%0d got y=%h z=%b sp=%0d fn=%b exp y=%h z=%b sp=%0d fn=%b",
                         i, y, zeror, sp, fulln, m_y(), (m_r == 12'd0), m_q.size(), (m_q.size() != 5));
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1;
        m_reset();
        test_reset();
        test_loop_count();
        test_overflow();
        test_underflow_clear();
        test_ymux_incr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
